// File: rtl/lod_rr_arbiter_if.sv
// Requester-bank <-> arbiter handshake bundle.
//   req_in        : level request per requester (bit i = requester i)
//   release_in    : current owner is done (only meaningful while grant_valid)
//   lock_in       : owner asks to suppress the hold timeout (only while grant_valid)
//   grant_valid   : a grant is active
//   grant_out     : one-hot grant, zero when idle
//   grant_idx     : index of the granted requester, holds last winner when idle
//   timeout_pulse : one-cycle flag marking a forced release
// master = requester side, slave = arbiter side.
interface lod_rr_arbiter_if;
  logic [7:0] req_in;
  logic       release_in;
  logic       lock_in;
  logic       grant_valid;
  logic [7:0] grant_out;
  logic [2:0] grant_idx;
  logic       timeout_pulse;

  modport master (
    output req_in, release_in, lock_in,
    input  grant_valid, grant_out, grant_idx, timeout_pulse
  );

  modport slave (
    input  req_in, release_in, lock_in,
    output grant_valid, grant_out, grant_idx, timeout_pulse
  );
endinterface

// File: rtl/lod_rr_arbiter.sv
// 8-way arbiter sharing one downstream port among eight requesters.
// The winner is found with a highest-index-first leading-one search whose
// start point rotates (RR_EN=1) so the last winner has lowest priority, or
// is fixed at index 7 (RR_EN=0). A grant is held until the owner releases,
// drops its request, or exceeds MAX_HOLD cycles without lock_in.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset, dominates all inputs
//   arb : lod_rr_arbiter_if.slave bundle (requests in, registered grant out)
// Parameters:
//   RR_EN    : 1 = round-robin start point, 0 = fixed priority (7 highest)
//   MAX_HOLD : maximum grant length in cycles, 2..255
module lod_rr_arbiter #(
  parameter bit          RR_EN    = 1'b1,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  lod_rr_arbiter_if.slave  arb
);

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       grant_valid_q, grant_valid_d;
  logic [7:0] grant_out_q, grant_out_d;
  logic [2:0] grant_idx_q, grant_idx_d;
  logic       timeout_q, timeout_d;

  logic [2:0] start_idx;
  logic [2:0] winner;
  logic       rel_any;
  logic       to_hit;

  // Descending search from 'start' with wrap 0->7. The request vector is
  // rotated so that bit 'start' lands at position 7; a plain leading-one
  // search then finds the winner, which is rotated back. All index math is
  // 3-bit so the mod-8 wrap is implicit.
  function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] start);
    logic [7:0] rot;
    logic [2:0] src;
    logic [2:0] k;
    k = '0;
    for (int i = 0; i < 8; i++) begin
      src    = 3'(i) + start + 3'd1;
      rot[i] = req[src];
    end
    for (int i = 0; i < 8; i++) begin
      if (rot[i]) k = 3'(i);
    end
    return k + start + 3'd1;
  endfunction

  assign start_idx = RR_EN ? (ptr_q - 3'd1) : 3'd7;
  assign winner    = rr_pick(arb.req_in, start_idx);

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    hold_cnt_d    = hold_cnt_q;
    grant_valid_d = grant_valid_q;
    grant_out_d   = grant_out_q;
    grant_idx_d   = grant_idx_q;
    timeout_d     = 1'b0;
    rel_any       = 1'b0;
    to_hit        = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb.req_in != 8'd0) begin
          state_d       = GRANT;
          ptr_d         = winner;
          hold_cnt_d    = 8'd0;
          grant_valid_d = 1'b1;
          grant_out_d   = 8'd1 << winner;
          grant_idx_d   = winner;
        end
      end
      GRANT: begin
        // Explicit or implicit release wins over a coincident timeout.
        rel_any    = arb.release_in || !arb.req_in[grant_idx_q];
        to_hit     = (hold_cnt_q == HOLD_LIM) && !arb.lock_in;
        hold_cnt_d = (hold_cnt_q == HOLD_LIM) ? hold_cnt_q : hold_cnt_q + 8'd1;
        if (rel_any || to_hit) begin
          state_d       = IDLE;
          grant_valid_d = 1'b0;
          grant_out_d   = 8'd0;
          timeout_d     = !rel_any;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= 3'd0;
      hold_cnt_q    <= 8'd0;
      grant_valid_q <= 1'b0;
      grant_out_q   <= 8'd0;
      grant_idx_q   <= 3'd0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hold_cnt_q    <= hold_cnt_d;
      grant_valid_q <= grant_valid_d;
      grant_out_q   <= grant_out_d;
      grant_idx_q   <= grant_idx_d;
      timeout_q     <= timeout_d;
    end
  end

  assign arb.grant_valid   = grant_valid_q;
  assign arb.grant_out     = grant_out_q;
  assign arb.grant_idx     = grant_idx_q;
  assign arb.timeout_pulse = timeout_q;

endmodule

// File: doc/lod_rr_arbiter.md
# lod_rr_arbiter

Sequential 8-way arbiter that shares one downstream resource among eight requesters. Winner selection uses the same highest-index-first leading-one search as the team's leading-one detector, with a rotating start point for round-robin fairness. The block holds each grant until the owner releases it, drops its request, or overruns a hold timeout. It sits between the requester bank and the shared datapath port it gates.

## Interface
- `RR_EN`, default 1: 1 = round-robin (rotating start point); 0 = fixed priority, index 7 highest, pure leading-one order.
- `MAX_HOLD`, default 16: maximum cycles a grant may stay asserted; legal range 2..255.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_in` in 8: level request per requester; bit i = requester i.
- `release_in` in 1: current owner finished; meaningful only while `grant_valid` = 1.
- `lock_in` in 1: owner requests timeout suppression; meaningful only while `grant_valid` = 1.
- `grant_valid` out 1: a grant is active.
- `grant_out` out 8: one-hot grant; all zero when `grant_valid` = 0.
- `grant_idx` out 3: index of the granted requester; holds the last winner when idle.
- `timeout_pulse` out 1: one-cycle flag marking a forced release.

## Operation
- **FSM states:** IDLE, GRANT.
- **IDLE:**
  - If `req_in` ≠ 0, select a winner, load `grant_idx` and `grant_out`, set `grant_valid`, clear `hold_cnt`, and go to GRANT.
  - Otherwise stay in IDLE.
- **Winner search:**
  - Scan descending from start index S, wrapping 0→7.
  - The first set bit wins.
  - RR_EN=1: S = (`ptr` − 1) mod 8.
  - RR_EN=0: S = 7 always.
- **Pointer `ptr` (3 bits):**
  - Reset value 0, so the first search starts at 7, identical to LOD order.
  - Loaded with the winner index on every IDLE→GRANT transition.
  - As a result, the last winner has the lowest priority in the next search.
- **GRANT:** `hold_cnt` increments every cycle and saturates at MAX_HOLD−1. Exit to IDLE (grant outputs cleared) on the first of:
  - (a) `release_in` = 1;
  - (b) `req_in[grant_idx]` = 0, i.e. an implicit release;
  - (c) `hold_cnt` = MAX_HOLD−1 and `lock_in` = 0, i.e. a timeout.
- **Timeout:** `timeout_pulse` = 1 only on the IDLE-entry cycle caused by condition (c).
- **Simultaneous events:**
  - Release (a or b) together with the timeout condition: treated as a release; `timeout_pulse` stays 0.
  - `lock_in` = 1 while `hold_cnt` is at its limit: the grant holds, `hold_cnt` stays saturated, and the timeout fires on the first cycle `lock_in` = 0.
  - Requests arriving while in GRANT are ignored until the next IDLE evaluation. No preemption.
- **Reset:**
  - Reset values: `grant_valid`=0, `grant_out`=0, `grant_idx`=0, `timeout_pulse`=0, `ptr`=0, `hold_cnt`=0, state IDLE.
  - Reset asserted mid-grant clears all of these at the next edge.
  - `rst` takes precedence over all other inputs.

## Timing
- All outputs are registered.
- **Grant latency:** a request sampled in IDLE at edge E produces `grant_valid` = 1 in the cycle after E.
- **Release latency:** a release or timeout condition sampled at edge E produces `grant_valid` = 0 after E.
- **Idle gap:** at least one cycle with `grant_valid` = 0 between consecutive grants. The earliest next grant is visible after edge E+1.
- **Grant length:**
  - With no release and no lock, `grant_valid` is high for exactly MAX_HOLD cycles.
  - Timeout lands on the same cycle as the grant deassertion.
- **Grant stability:** `grant_out` and `grant_idx` are stable for the whole grant.

## Test plan
- **Reset / first grant:** apply `rst`, then `req_in`=8'b0010_0100 → one cycle later `grant_valid`=1, `grant_idx`=5, `grant_out`=8'b0010_0000.
- **Round-robin rotation:** RR_EN=1, `req_in`=8'hFF held, `release_in` pulsed after each grant → `grant_idx` sequence 7,6,5,4,3,2,1,0,7. Each grant is separated by exactly one idle cycle.
- **Fixed priority:** RR_EN=0, `req_in`=8'b1000_0001, releases pulsed → `grant_idx` stays 7 every grant. Requester 0 is granted only after `req_in[7]` drops.
- **Timeout:** MAX_HOLD=16, `req_in`=8'h08 held, no release → `grant_valid` high for 16 cycles. `timeout_pulse`=1 on the cycle `grant_valid` falls, then re-grant to index 3 after one idle cycle.
- **Lock and simultaneous events:**
  - `lock_in`=1 through cycle 20 of a grant → no timeout until `lock_in` falls. `timeout_pulse` is then raised on the next edge.
  - `release_in`=1 on cycle 16 → release only, `timeout_pulse`=0.
- **Mid-operation disturbances:**
  - Drop `req_in[grant_idx]` mid-grant → grant ends next edge with no timeout.
  - Assert `rst` mid-grant → all outputs 0 next edge. A subsequent search starts again at index 7.
